gcd_job_feeder: RTL

Upstream stage of the GCD FSMD core (gcd_control plus its datapath). Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Launches one GCD computation at a time by driving the core's x/y inputs and go pulse, then returns each result over a valid/ready stream. Resolves zero operands locally, because the subtraction loop never terminates when one operand is 0. Guards every core run with a watchdog.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_fifo.sv | 47 ++++
 rtl/gcd_job_feeder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD job feeder and its operand FIFO.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESULT = 2'b11
    } state_e;

    // Bits needed to index v entries (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/gcd_fifo.sv
// Operand-pair FIFO; pointers carry a wrap bit so full and empty are distinguishable.
module gcd_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gcd_job_feeder.sv
// Feeds queued operand pairs to the GCD core one at a time, short-circuits zero
// operands, and bounds every core run with a watchdog.
module gcd_job_feeder
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = GCD_WIDTH,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    output logic             core_go,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    localparam int unsigned    WDW     = clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_e           state_q;
    logic [WDW-1:0]   wd_q;
    logic [WIDTH-1:0] core_x_q;
    logic [WIDTH-1:0] core_y_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_err_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [2*WIDTH-1:0] fifo_rdata;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    assign in_ready        = !fifo_full;
    assign fifo_push       = in_valid && !fifo_full;
    assign fifo_pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign {head_a, head_b} = fifo_rdata;

    gcd_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Job sequencer: a zero operand never reaches the core since its loop would not terminate.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wd_q       <= '0;
            core_x_q   <= '0;
            core_y_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        core_x_q  <= head_a;
                        core_y_q  <= head_b;
                        res_err_q <= 1'b0;
                        if (head_a == '0 || head_b == '0) begin
                            res_data_q <= head_a | head_b;
                            state_q    <= ST_RESULT;
                        end else begin
                            state_q <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        res_data_q <= core_result;
                        state_q    <= ST_RESULT;
                    end else if (wd_q == WD_LAST) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state_q    <= ST_RESULT;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                ST_RESULT: begin
                    if (res_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_x    = core_x_q;
    assign core_y    = core_y_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign core_go   = (state_q == ST_LAUNCH);
    assign res_valid = (state_q == ST_RESULT);
    assign busy      = (state_q != ST_IDLE);

endmodule
